// File: rtl/mem_pkg.sv
// Shared constants and FSM encoding for the burst memory controller.
package mem_pkg;

    localparam int unsigned DefDw = 16;
    localparam int unsigned DefAw = 25;
    localparam int unsigned DefLw = 5;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StWr    = 2'd1,
        StRd    = 2'd2,
        StDrain = 2'd3
    } state_e;

endpackage

// File: rtl/rd_skid_fifo.sv
// Two-entry response buffer that absorbs read data already in flight when the consumer stalls.
module rd_skid_fifo
    import mem_pkg::*;
#(
    parameter int unsigned DW = DefDw
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push_i,
    input  logic [DW-1:0] push_data_i,
    input  logic          pop_i,
    output logic [1:0]    count_o,
    output logic [DW-1:0] data_o
);

    logic [DW-1:0] mem_q [2];
    logic          wr_ptr_q;
    logic          rd_ptr_q;
    logic [1:0]    count_q;
    logic          do_push;
    logic          do_pop;

    // A pop on an empty buffer is ignored; a push into a full buffer only lands with a pop.
    assign do_pop  = pop_i && (count_q != 2'd0);
    assign do_push = push_i && ((count_q != 2'd2) || do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_data_i;
            end
            wr_ptr_q <= wr_ptr_q ^ do_push;
            rd_ptr_q <= rd_ptr_q ^ do_pop;
            count_q  <= count_q + 2'(do_push) - 2'(do_pop);
        end
    end

    assign count_o = count_q;
    assign data_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/mem_burst_ctrl.sv
// Burst controller: turns write/read burst commands into single-beat memory accesses.
module mem_burst_ctrl
    import mem_pkg::*;
#(
    parameter int unsigned DW = DefDw,
    parameter int unsigned AW = DefAw,
    parameter int unsigned LW = DefLw
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic          cmd_wr,
    input  logic [AW-1:0] cmd_addr,
    input  logic [LW-1:0] cmd_len,
    input  logic          wd_valid,
    output logic          wd_ready,
    input  logic [DW-1:0] wd_data,
    output logic          rd_valid,
    input  logic          rd_ready,
    output logic [DW-1:0] rd_data,
    output logic          mem_cs,
    output logic          mem_wen,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy,
    output logic          done
);

    state_e        state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [LW-1:0] cnt_q, cnt_d;
    logic          inflight_q, inflight_d;
    logic          done_q, done_d;
    logic [1:0]    occ;
    logic          pop;
    logic          issue_ok;
    logic          drain_done;

    rd_skid_fifo #(
        .DW(DW)
    ) u_rd_skid_fifo (
        .clk        (clk),
        .rst        (rst),
        .push_i     (inflight_q),
        .push_data_i(mem_rdata),
        .pop_i      (pop),
        .count_o    (occ),
        .data_o     (rd_data)
    );

    assign rd_valid = (occ != 2'd0);
    assign pop      = rd_valid && rd_ready;
    // Issue only if the buffer can still take this beat after everything already in flight.
    assign issue_ok = (({1'b0, occ} + {2'b00, inflight_q}) < (3'd2 + {2'b00, pop}));

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        cnt_d      = cnt_q;
        inflight_d = 1'b0;
        done_d     = 1'b0;
        drain_done = 1'b0;
        cmd_ready  = 1'b0;
        wd_ready   = 1'b0;
        mem_cs     = 1'b0;
        mem_wen    = 1'b0;
        mem_wdata  = '0;
        unique case (state_q)
            StIdle: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    addr_d  = cmd_addr;
                    cnt_d   = cmd_len;
                    state_d = cmd_wr ? StWr : StRd;
                end
            end
            StWr: begin
                wd_ready = 1'b1;
                if (wd_valid) begin
                    mem_cs    = 1'b1;
                    mem_wen   = 1'b1;
                    mem_wdata = wd_data;
                    addr_d    = addr_q + AW'(1);
                    cnt_d     = cnt_q - LW'(1);
                    if (cnt_q == '0) begin
                        state_d = StIdle;
                        done_d  = 1'b1;
                    end
                end
            end
            StRd: begin
                if (issue_ok) begin
                    mem_cs     = 1'b1;
                    inflight_d = 1'b1;
                    addr_d     = addr_q + AW'(1);
                    cnt_d      = cnt_q - LW'(1);
                    if (cnt_q == '0) begin
                        state_d = StDrain;
                    end
                end
            end
            StDrain: begin
                if ((occ == 2'd0) && !inflight_q) begin
                    drain_done = 1'b1;
                    state_d    = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            addr_q     <= '0;
            cnt_q      <= '0;
            inflight_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            cnt_q      <= cnt_d;
            inflight_q <= inflight_d;
            done_q     <= done_d;
        end
    end

    assign mem_addr = addr_q;
    assign busy     = (state_q != StIdle);
    assign done     = done_q || drain_done;

endmodule

// File: tb/tb_mem_burst_ctrl.sv
// Scoreboard bench for mem_burst_ctrl with a 16-entry synchronous memory model.
module tb_mem_burst_ctrl;

    localparam int unsigned DW = 16;
    localparam int unsigned AW = 4;
    localparam int unsigned LW = 5;

    logic          clk;
    logic          rst;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_wr;
    logic [AW-1:0] cmd_addr;
    logic [LW-1:0] cmd_len;
    logic          wd_valid;
    logic          wd_ready;
    logic [DW-1:0] wd_data;
    logic          rd_valid;
    logic          rd_ready;
    logic [DW-1:0] rd_data;
    logic          mem_cs;
    logic          mem_wen;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          busy;
    logic          done;

    mem_burst_ctrl #(
        .DW(DW),
        .AW(AW),
        .LW(LW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_wr   (cmd_wr),
        .cmd_addr (cmd_addr),
        .cmd_len  (cmd_len),
        .wd_valid (wd_valid),
        .wd_ready (wd_ready),
        .wd_data  (wd_data),
        .rd_valid (rd_valid),
        .rd_ready (rd_ready),
        .rd_data  (rd_data),
        .mem_cs   (mem_cs),
        .mem_wen  (mem_wen),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .busy     (busy),
        .done     (done)
    );

    logic [DW-1:0] mem_m  [16];
    logic [DW-1:0] shadow [16];
    logic [19:0]   wq [$];
    logic [DW-1:0] rq [$];
    logic [19:0]   wexp;
    logic [DW-1:0] rexp;
    int n_checks = 0;
    int n_fail = 0;
    int done_cnt = 0;
    int rd_cs_cnt = 0;
    int wr_cs_cnt = 0;
    int pop_n = 0;
    int first_pop = 0;
    int last_pop = 0;
    int cyc = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc++;
        if (mem_cs) begin
            if (mem_wen) mem_m[mem_addr] <= mem_wdata;
            else         mem_rdata <= mem_m[mem_addr];
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (done) done_cnt++;
            if (mem_cs && !mem_wen) rd_cs_cnt++;
            if (mem_cs && mem_wen) begin
                wr_cs_cnt++;
                if (wq.size() == 0) begin
                    check_eq("wr_unexpected", 32'd1, 32'd0);
                end else begin
                    wexp = wq.pop_front();
                    check_eq("wr_addr", 32'(mem_addr), 32'(wexp[19:16]));
                    check_eq("wr_data", 32'(mem_wdata), 32'(wexp[15:0]));
                end
            end
            if (rd_valid && rd_ready) begin
                if (pop_n == 0) first_pop = cyc;
                last_pop = cyc;
                pop_n++;
                if (rq.size() == 0) begin
                    check_eq("rd_unexpected", 32'd1, 32'd0);
                end else begin
                    rexp = rq.pop_front();
                    check_eq("rd_data", 32'(rd_data), 32'(rexp));
                end
            end
        end
    end

    task automatic send_cmd(input logic wr, input logic [AW-1:0] a, input logic [LW-1:0] len);
        int n = 0;
        @(posedge clk);
        #1;
        cmd_valid = 1'b1;
        cmd_wr    = wr;
        cmd_addr  = a;
        cmd_len   = len;
        @(negedge clk);
        while (!cmd_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) check_eq("cmd_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic drive_beat(input logic [AW-1:0] ad, input logic [DW-1:0] d, input logic last);
        int n = 0;
        wq.push_back({ad, d});
        shadow[ad] = d;
        wd_valid = 1'b1;
        wd_data  = d;
        @(negedge clk);
        while (!wd_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!wd_ready) check_eq("wd_timeout", 32'd0, 32'd1);
        if (last) check_eq("wr_done_early", 32'(done), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic wr_burst(input logic [AW-1:0] a, input int len, input logic [DW-1:0] base);
        int d0 = done_cnt;
        int c0 = wr_cs_cnt;
        send_cmd(1'b1, a, LW'(len));
        for (int i = 0; i <= len; i++) begin
            drive_beat(a + AW'(i), base + DW'(i), i == len);
        end
        wd_valid = 1'b0;
        check_eq("wr_done", 32'(done), 32'd1);
        check_eq("wr_idle", 32'(busy), 32'd0);
        check_eq("wr_beats", 32'(wr_cs_cnt - c0), 32'(len + 1));
        check_eq("wr_q_empty", 32'(wq.size()), 32'd0);
        @(posedge clk);
        #1;
        check_eq("wr_done_once", 32'(done_cnt - d0), 32'd1);
    endtask

    task automatic rd_burst(input logic [AW-1:0] a, input int len, input int stall);
        int d0 = done_cnt;
        int c0 = rd_cs_cnt;
        int n = 0;
        pop_n = 0;
        for (int i = 0; i <= len; i++) rq.push_back(shadow[a + AW'(i)]);
        rd_ready = (stall == 0);
        send_cmd(1'b0, a, LW'(len));
        if (stall > 0) begin
            repeat (stall) @(posedge clk);
            #1;
            check_eq("stall_issues_le2", 32'((rd_cs_cnt - c0) <= 2), 32'd1);
            check_eq("stall_valid", 32'(rd_valid), 32'd1);
            check_eq("stall_no_pop", 32'(pop_n), 32'd0);
            rd_ready = 1'b1;
        end
        @(negedge clk);
        while (!done && n < 64) begin
            @(negedge clk);
            n++;
        end
        check_eq("rd_done_seen", 32'(done), 32'd1);
        check_eq("rd_done_empty", 32'(rd_valid), 32'd0);
        check_eq("rd_all_popped", 32'(rq.size()), 32'd0);
        check_eq("rd_issues", 32'(rd_cs_cnt - c0), 32'(len + 1));
        @(posedge clk);
        #1;
        rd_ready = 1'b0;
        check_eq("rd_idle", 32'(busy), 32'd0);
        check_eq("rd_done_once", 32'(done_cnt - d0), 32'd1);
        if (stall == 0) check_eq("rd_back_to_back", 32'(last_pop - first_pop), 32'(len));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: no finish within time limit");
        $fatal(1);
    end

    initial begin
        int d0;
        rst = 1'b1;
        cmd_valid = 1'b0;
        cmd_wr = 1'b0;
        cmd_addr = '0;
        cmd_len = '0;
        wd_valid = 1'b0;
        wd_data = '0;
        rd_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_mem_cs", 32'(mem_cs), 32'd0);
        check_eq("rst_mem_wen", 32'(mem_wen), 32'd0);
        check_eq("rst_mem_addr", 32'(mem_addr), 32'd0);
        check_eq("rst_mem_wdata", 32'(mem_wdata), 32'd0);
        check_eq("rst_wd_ready", 32'(wd_ready), 32'd0);
        check_eq("rst_rd_valid", 32'(rd_valid), 32'd0);
        check_eq("rst_rd_data", 32'(rd_data), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Stray write data and read-ready in IDLE must not cause accesses.
        wd_valid = 1'b1;
        rd_ready = 1'b1;
        @(negedge clk);
        check_eq("idle_wd_ready", 32'(wd_ready), 32'd0);
        check_eq("idle_mem_cs", 32'(mem_cs), 32'd0);
        wd_valid = 1'b0;
        rd_ready = 1'b0;

        wr_burst(4'h3, 3, 16'h00A0);
        rd_burst(4'h3, 3, 0);
        wr_burst(4'hE, 3, 16'h00B0);
        rd_burst(4'hE, 3, 0);
        wr_burst(4'h8, 7, 16'h00C0);
        rd_burst(4'h8, 7, 6);
        wr_burst(4'h2, 0, 16'h00D0);
        rd_burst(4'h2, 0, 0);

        // Abort a write burst after two of four beats.
        d0 = done_cnt;
        send_cmd(1'b1, 4'h9, 5'd3);
        drive_beat(4'h9, 16'h00F0, 1'b0);
        drive_beat(4'hA, 16'h00F1, 1'b0);
        wd_valid = 1'b0;
        rst = 1'b1;
        #1;
        check_eq("abort_busy", 32'(busy), 32'd0);
        check_eq("abort_cmd_ready", 32'(cmd_ready), 32'd1);
        check_eq("abort_done", 32'(done), 32'd0);
        check_eq("abort_mem_cs", 32'(mem_cs), 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("abort_no_done", 32'(done_cnt - d0), 32'd0);
        check_eq("abort_idle", 32'(busy), 32'd0);
        check_eq("abort_q_empty", 32'(wq.size()), 32'd0);

        wr_burst(4'h5, 1, 16'h00E0);
        rd_burst(4'h5, 1, 0);
        rd_burst(4'h9, 1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
